// File: rtl/nts_api_pkg.sv
// Shared definitions for the API arbiter: FSM encoding and read-latency bounds.
package nts_api_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;
    localparam int CNT_W   = 3;   // wide enough to hold LAT_MAX

endpackage

// File: rtl/nts_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins; on contention the port not granted last wins.
module nts_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt,
    output logic       vld
);

    assign vld = |req;
    assign gnt = (req == 2'b11) ? ~last_gnt : req[1];

endmodule

// File: rtl/nts_api_arbiter.sv
// Arbitrates two requesters onto a single API decoder port; one transaction in flight at a time.
module nts_api_arbiter
    import nts_api_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_req0,
    input  logic        i_we0,
    input  logic [11:0] i_addr0,
    input  logic [31:0] i_wdata0,
    output logic        o_ack0,
    output logic [31:0] o_rdata0,
    input  logic        i_req1,
    input  logic        i_we1,
    input  logic [11:0] i_addr1,
    input  logic [31:0] i_wdata1,
    output logic        o_ack1,
    output logic [31:0] o_rdata1,
    output logic        o_api_cs,
    output logic        o_api_we,
    output logic [11:0] o_api_address,
    output logic [31:0] o_api_write_data,
    input  logic [31:0] i_api_read_data,
    output logic        o_busy
);

    state_t             state, state_nxt;
    logic               lat_we;
    logic [11:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic               gnt;
    logic               last_gnt;
    logic [CNT_W-1:0]   cnt;
    logic               arb_gnt, arb_vld;
    logic [31:0]        rdata0, rdata1;

    nts_rr_arbiter2 u_rr (
        .req      ({i_req1, i_req0}),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt),
        .vld      (arb_vld)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arb_vld) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = ST_WAIT;
            ST_WAIT:    if (cnt == CNT_W'(1)) state_nxt = ST_RESPOND;
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Requests are only looked at in IDLE, so later field changes cannot disturb a latched access.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            cnt       <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (arb_vld) begin
                    gnt       <= arb_gnt;
                    last_gnt  <= arb_gnt;
                    lat_we    <= arb_gnt ? i_we1    : i_we0;
                    lat_addr  <= arb_gnt ? i_addr1  : i_addr0;
                    lat_wdata <= arb_gnt ? i_wdata1 : i_wdata0;
                end
                ST_ACCESS: cnt <= CNT_W'(READ_LATENCY);
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (gnt) rdata1 <= i_api_read_data;
                        else     rdata0 <= i_api_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_api_cs         = (state == ST_ACCESS);
    assign o_api_we         = o_api_cs & lat_we;
    assign o_api_address    = o_api_cs ? lat_addr  : '0;
    assign o_api_write_data = o_api_cs ? lat_wdata : '0;
    assign o_ack0           = (state == ST_RESPOND) & ~gnt;
    assign o_ack1           = (state == ST_RESPOND) &  gnt;
    assign o_rdata0         = rdata0;
    assign o_rdata1         = rdata1;
    assign o_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Directed + random bench for nts_api_arbiter; three instances at read latencies 1, 3 and 7.
module tb_nts_api_arbiter;

    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic        req   [N][2];
    logic        we    [N][2];
    logic [11:0] addr  [N][2];
    logic [31:0] wdata [N][2];
    logic        ack   [N][2];
    logic [31:0] rdata [N][2];
    logic        cs    [N];
    logic        api_we[N];
    logic [11:0] api_addr [N];
    logic [31:0] api_wdata[N];
    logic [31:0] rd       [N];
    logic [31:0] model_rd [N];
    logic        fixed_en [N];
    logic [31:0] fixed_val[N];
    logic        busy  [N];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          outst [N];
    int          n_ack [N];
    logic [11:0] exp_addr [N][2];
    logic        gnt_seq [4];
    int          n_rr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder stand-in: returns a tag of the address seen at chip select, or a forced value.
    always @(posedge clk)
        for (int g = 0; g < N; g++)
            if (cs[g]) model_rd[g] <= {20'h5A5A5, api_addr[g]};

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign rd[g] = fixed_en[g] ? fixed_val[g] : model_rd[g];
        nts_api_arbiter #(.READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 7))) u_dut (
            .i_clk            (clk),
            .i_areset_n       (rst_n),
            .i_req0           (req[g][0]),
            .i_we0            (we[g][0]),
            .i_addr0          (addr[g][0]),
            .i_wdata0         (wdata[g][0]),
            .o_ack0           (ack[g][0]),
            .o_rdata0         (rdata[g][0]),
            .i_req1           (req[g][1]),
            .i_we1            (we[g][1]),
            .i_addr1          (addr[g][1]),
            .i_wdata1         (wdata[g][1]),
            .o_ack1           (ack[g][1]),
            .o_rdata1         (rdata[g][1]),
            .o_api_cs         (cs[g]),
            .o_api_we         (api_we[g]),
            .o_api_address    (api_addr[g]),
            .o_api_write_data (api_wdata[g]),
            .i_api_read_data  (rd[g]),
            .o_busy           (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor on every instance: exclusive acks, quiet bus, one transaction in flight.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                outst[g] = 0;
            end else begin
                check("ack_exclusive", 32'(ack[g][0] & ack[g][1]), 32'd0);
                if (!cs[g])
                    check("bus_zero", api_wdata[g] | 32'(api_addr[g]) | 32'(api_we[g]), 32'd0);
                if (cs[g] || ack[g][0] || ack[g][1])
                    check("busy_active", 32'(busy[g]), 32'd1);
                if (ack[g][0] || ack[g][1]) begin
                    check("ack_outstanding", 32'(outst[g]), 32'd1);
                    outst[g] = outst[g] - 1;
                end
                if (cs[g]) begin
                    check("cs_overlap", 32'(outst[g]), 32'd0);
                    outst[g] = outst[g] + 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            fixed_en[g] = 1'b0; fixed_val[g] = '0; n_ack[g] = 0; outst[g] = 0;
            for (int p = 0; p < 2; p++) begin
                req[g][p] = 1'b0; we[g][p] = 1'b0; addr[g][p] = '0; wdata[g][p] = '0;
                exp_addr[g][p] = '0;
            end
        end
        repeat (3) tick();

        // reset state
        check("rst_cs",     32'(cs[0]), 32'd0);
        check("rst_we",     32'(api_we[0]), 32'd0);
        check("rst_addr",   32'(api_addr[0]), 32'd0);
        check("rst_wdata",  api_wdata[0], 32'd0);
        check("rst_ack0",   32'(ack[0][0]), 32'd0);
        check("rst_ack1",   32'(ack[0][1]), 32'd0);
        check("rst_rdata0", rdata[0][0], 32'd0);
        check("rst_rdata1", rdata[2][1], 32'd0);
        check("rst_busy",   32'(busy[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // port 0 write, L=1: cs in cycle 1, ack in cycle 3
        req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 12'h010; wdata[0][0] = 32'hDEADBEEF;
        tick();
        check("wr_cs",    32'(cs[0]), 32'd1);
        check("wr_we",    32'(api_we[0]), 32'd1);
        check("wr_addr",  32'(api_addr[0]), 32'h010);
        check("wr_wdata", api_wdata[0], 32'hDEADBEEF);
        check("wr_busy",  32'(busy[0]), 32'd1);
        tick();
        check("wr_cs_off",    32'(cs[0]), 32'd0);
        check("wr_ack_early", 32'(ack[0][0]), 32'd0);
        tick();
        check("wr_ack0",  32'(ack[0][0]), 32'd1);
        check("wr_ack1",  32'(ack[0][1]), 32'd0);
        check("wr_rdata", rdata[0][0], 32'h5A5A5010);
        req[0][0] = 1'b0; we[0][0] = 1'b0;
        tick();
        check("wr_ack_pulse", 32'(ack[0][0]), 32'd0);
        check("wr_idle_busy", 32'(busy[0]), 32'd0);

        // port 1 read, L=3: ack in cycle 5 with decoder data, then held
        fixed_en[1] = 1'b1; fixed_val[1] = 32'h12345678;
        req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 12'h081;
        tick();
        check("rd_cs",   32'(cs[1]), 32'd1);
        check("rd_addr", 32'(api_addr[1]), 32'h081);
        check("rd_we",   32'(api_we[1]), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("rd_ack_early", 32'(ack[1][1]), 32'd0);
        end
        tick();
        check("rd_ack1",  32'(ack[1][1]), 32'd1);
        check("rd_ack0",  32'(ack[1][0]), 32'd0);
        check("rd_rdata", rdata[1][1], 32'h12345678);
        req[1][1] = 1'b0; fixed_val[1] = 32'h0;
        repeat (3) tick();
        check("rd_ack_pulse", 32'(ack[1][1]), 32'd0);
        check("rd_hold",      rdata[1][1], 32'h12345678);
        check("rd_idle_busy", 32'(busy[1]), 32'd0);
        fixed_en[1] = 1'b0;

        // contention from reset: grants alternate starting with port 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req[0][0] = 1'b1; addr[0][0] = 12'h100;
        req[0][1] = 1'b1; addr[0][1] = 12'h200;
        n_rr = 0;
        for (int c = 0; c < 40 && n_rr < 4; c++) begin
            tick();
            if (ack[0][0] || ack[0][1]) begin
                gnt_seq[n_rr] = ack[0][1];
                n_rr++;
            end
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        check("rr_count", 32'(n_rr), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr_grant", 32'(gnt_seq[i]), 32'(i % 2));
        check("rr_rdata0", rdata[0][0], 32'h5A5A5100);
        check("rr_rdata1", rdata[0][1], 32'h5A5A5200);
        repeat (6) tick();
        check("rr_idle_busy", 32'(busy[0]), 32'd0);

        // reset asserted in WAIT aborts silently; a fresh request then completes
        req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 12'h033;
        repeat (3) tick();
        check("ab_in_wait", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ab_busy",  32'(busy[1]), 32'd0);
        check("ab_cs",    32'(cs[1]), 32'd0);
        check("ab_ack0",  32'(ack[1][0]), 32'd0);
        check("ab_rdata", rdata[1][0], 32'd0);
        req[1][0] = 1'b0;
        repeat (2) tick();
        check("ab_no_ack", 32'(ack[1][0]), 32'd0);
        rst_n = 1'b1;
        tick();
        req[1][0] = 1'b1; addr[1][0] = 12'h044;
        tick();
        check("ab_new_cs",   32'(cs[1]), 32'd1);
        check("ab_new_addr", 32'(api_addr[1]), 32'h044);
        repeat (3) tick();
        check("ab_new_early", 32'(ack[1][0]), 32'd0);
        tick();
        check("ab_new_ack",   32'(ack[1][0]), 32'd1);
        check("ab_new_rdata", rdata[1][0], 32'h5A5A5044);
        req[1][0] = 1'b0;
        tick();

        // address change during WAIT must not reach the decoder
        req[1][0] = 1'b1; addr[1][0] = 12'h055;
        tick();
        check("chg_addr", 32'(api_addr[1]), 32'h055);
        tick();
        addr[1][0] = 12'h1FF; we[1][0] = 1'b1;
        tick();
        check("chg_cs_off", 32'(cs[1]), 32'd0);
        repeat (2) tick();
        check("chg_ack",   32'(ack[1][0]), 32'd1);
        check("chg_rdata", rdata[1][0], 32'h5A5A5055);
        req[1][0] = 1'b0; we[1][0] = 1'b0;
        tick();

        // random traffic on all three latencies; each ack must return its own address tag
        for (int c = 0; c < 640; c++) begin
            tick();
            for (int g = 0; g < N; g++)
                for (int p = 0; p < 2; p++) begin
                    if (ack[g][p]) begin
                        check("rand_rdata", rdata[g][p], {20'h5A5A5, exp_addr[g][p]});
                        n_ack[g]++;
                        req[g][p] = 1'b0;
                    end else if (!req[g][p] && c < 600 && $urandom_range(3) == 0) begin
                        req[g][p]      = 1'b1;
                        we[g][p]       = 1'($urandom_range(1));
                        addr[g][p]     = 12'($urandom);
                        wdata[g][p]    = $urandom;
                        exp_addr[g][p] = addr[g][p];
                    end
                end
        end
        for (int g = 0; g < N; g++) begin
            check("rand_drained", 32'(outst[g]), 32'd0);
            check("rand_progress", 32'(n_ack[g] >= 20), 32'd1);
            check("rand_idle", 32'(busy[g]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
